// File: rtl/ecg_frame_classifier_if.sv
// Sample/result bus between the ECG sample source, the frame classifier
// and the downstream class consumer.
interface ecg_frame_classifier_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 15,
  parameter int unsigned NUM_CLASS = 4
);
  logic                               start;
  logic                               ecg_valid;
  logic [DATA_W-1:0]                  ecg_input;
  logic                               busy;
  logic [$clog2(FRAME_LEN+1)-1:0]     sample_cnt;
  logic [NUM_CLASS-1:0]               classifier;
  logic                               class_valid;

  modport master (
    output start, ecg_valid, ecg_input,
    input  busy, sample_cnt, classifier, class_valid
  );

  modport slave (
    input  start, ecg_valid, ecg_input,
    output busy, sample_cnt, classifier, class_valid
  );
endinterface

// File: rtl/ecg_frame_classifier.sv
// Frame-based ECG classifier: tracks peak/trough over FRAME_LEN samples and
// bins the peak-to-peak range one-hot. ECG_FEAT_OUT_EN exposes feature ports.
module ecg_frame_classifier #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 15,
  parameter int unsigned NUM_CLASS = 4,
  parameter int unsigned BIN_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ecg_frame_classifier_if.slave bus
`ifdef ECG_FEAT_OUT_EN
  ,
  output logic [DATA_W-1:0]                   feat_max,
  output logic [DATA_W-1:0]                   feat_min,
  output logic [DATA_W+$clog2(FRAME_LEN)-1:0] feat_sum
`endif
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACQ, CLASSIFY, DONE} state_t;

  state_t               state_r, state_next;
  logic [DATA_W-1:0]    max_r, min_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_CLASS-1:0] class_r, class_next;
  logic [DATA_W-1:0]    rng, bin;
  logic                 clear, accept;

  // Restart wins over a same-cycle sample in ACQ.
  assign clear  = bus.start && (state_r == IDLE || state_r == ACQ || state_r == DONE);
  assign accept = (state_r == ACQ) && !bus.start && bus.ecg_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_next;
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:     if (bus.start) state_next = ACQ;
      ACQ:      if (accept && cnt_r == CNT_W'(FRAME_LEN - 1)) state_next = CLASSIFY;
      CLASSIFY: state_next = DONE;
      DONE:     state_next = bus.start ? ACQ : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_r == ACQ) || (state_r == CLASSIFY);
    bus.class_valid = (state_r == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_r <= '0;
      min_r <= '1;
      cnt_r <= '0;
    end else if (clear) begin
      max_r <= '0;
      min_r <= '1;
      cnt_r <= '0;
    end else if (accept) begin
      if (bus.ecg_input > max_r) max_r <= bus.ecg_input;
      if (bus.ecg_input < min_r) min_r <= bus.ecg_input;
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Range bin saturates into the top class.
  always_comb begin
    rng        = max_r - min_r;
    bin        = rng >> BIN_SHIFT;
    class_next = '0;
    if (bin >= DATA_W'(NUM_CLASS - 1)) begin
      class_next[NUM_CLASS-1] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_CLASS - 1; i++) begin
        if (bin == DATA_W'(i)) class_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   class_r <= '0;
    else if (state_r == CLASSIFY) class_r <= class_next;
  end

  assign bus.sample_cnt = cnt_r;
  assign bus.classifier = class_r;

`ifdef ECG_FEAT_OUT_EN
  localparam int unsigned SUM_W = DATA_W + $clog2(FRAME_LEN);

  // The sum only has a consumer when the feature ports exist.
  logic [SUM_W-1:0] sum_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sum_r <= '0;
    else if (clear)  sum_r <= '0;
    else if (accept) sum_r <= sum_r + SUM_W'(bus.ecg_input);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feat_max <= '0;
      feat_min <= '0;
      feat_sum <= '0;
    end else if (state_r == CLASSIFY) begin
      feat_max <= max_r;
      feat_min <= min_r;
      feat_sum <= sum_r;
    end
  end
`endif

endmodule

// File: tb/tb_ecg_frame_classifier.sv
// Directed self-checking bench for ecg_frame_classifier (default parameters).
module tb_ecg_frame_classifier;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ecg_frame_classifier_if #(.DATA_W(8), .FRAME_LEN(15), .NUM_CLASS(4)) bus ();

`ifdef ECG_FEAT_OUT_EN
  logic [7:0]  feat_max, feat_min;
  logic [11:0] feat_sum;
`endif

  ecg_frame_classifier #(.DATA_W(8), .FRAME_LEN(15), .NUM_CLASS(4), .BIN_SHIFT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ECG_FEAT_OUT_EN
    ,
    .feat_max (feat_max),
    .feat_min (feat_min),
    .feat_sum (feat_sum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] f1 [15] = '{8'd16, 8'd15, 8'd7, 8'd3, 8'd0, 8'd3, 8'd5, 8'd6,
                          8'd6, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    bus.ecg_valid = 1'b0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] x);
    bus.ecg_valid = 1'b1;
    bus.ecg_input = x;
    step();
    bus.ecg_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.ecg_valid = 1'b0; bus.ecg_input = '0;
    rst = 1'b0;
    step(); step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.sample_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.sample_cnt); end
    total++; if (bus.classifier !== 4'b0000) begin bad++; $display("FAIL rst_class got=%b exp=0000", bus.classifier); end
    total++; if (bus.class_valid !== 1'b0) begin bad++; $display("FAIL rst_cv got=%b exp=0", bus.class_valid); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_frame1();
    start_frame();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL f1_busy_acq got=%b exp=1", bus.busy); end
    for (int i = 0; i < 15; i++) begin
      feed(f1[i]);
      total++;
      if (bus.sample_cnt !== 4'(i + 1)) begin bad++; $display("FAIL f1_cnt[%0d] got=%0d exp=%0d", i, bus.sample_cnt, i + 1); end
      if (i < 14) begin
        total++; if (bus.class_valid !== 1'b0) begin bad++; $display("FAIL f1_early_cv[%0d] got=%b exp=0", i, bus.class_valid); end
      end
    end
    // CLASSIFY cycle: result not yet visible
    total++; if (bus.class_valid !== 1'b0) begin bad++; $display("FAIL f1_cv_e got=%b exp=0", bus.class_valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL f1_busy_cls got=%b exp=1", bus.busy); end
    step();
    total++; if (bus.class_valid !== 1'b1) begin bad++; $display("FAIL f1_cv_e1 got=%b exp=1", bus.class_valid); end
    total++; if (bus.classifier !== 4'b0100) begin bad++; $display("FAIL f1_class got=%b exp=0100", bus.classifier); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL f1_busy_done got=%b exp=0", bus.busy); end
    step();
    total++; if (bus.class_valid !== 1'b0) begin bad++; $display("FAIL f1_cv_e2 got=%b exp=0", bus.class_valid); end
    total++; if (bus.classifier !== 4'b0100) begin bad++; $display("FAIL f1_hold got=%b exp=0100", bus.classifier); end
  endtask

  task automatic test_flat();
    start_frame();
    for (int i = 0; i < 15; i++) feed(8'd7);
    step();
    total++; if (bus.class_valid !== 1'b1) begin bad++; $display("FAIL flat_cv got=%b exp=1", bus.class_valid); end
    total++; if (bus.classifier !== 4'b0001) begin bad++; $display("FAIL flat_class got=%b exp=0001", bus.classifier); end
    step();
  endtask

  task automatic test_extremes();
    start_frame();
    feed(8'd100); feed(8'd0); feed(8'd255);
    for (int i = 0; i < 12; i++) feed(8'd100);
    step();
    total++; if (bus.classifier !== 4'b1000) begin bad++; $display("FAIL ext_class got=%b exp=1000", bus.classifier); end
    step();
  endtask

  task automatic test_valid_gaps();
    start_frame();
    for (int i = 0; i < 15; i++) begin
      feed(f1[i]);
      bus.ecg_input = 8'd200;
      step();
      total++;
      if (bus.sample_cnt !== 4'(i + 1)) begin bad++; $display("FAIL gap_cnt[%0d] got=%0d exp=%0d", i, bus.sample_cnt, i + 1); end
      if (i == 14) begin
        total++; if (bus.class_valid !== 1'b1) begin bad++; $display("FAIL gap_cv got=%b exp=1", bus.class_valid); end
      end
    end
    total++; if (bus.classifier !== 4'b0100) begin bad++; $display("FAIL gap_class got=%b exp=0100", bus.classifier); end
    step();
  endtask

  task automatic test_restart();
    start_frame();
    for (int i = 0; i < 5; i++) feed((i % 2 == 0) ? 8'd200 : 8'd0);
    total++; if (bus.sample_cnt !== 4'd5) begin bad++; $display("FAIL rs_cnt5 got=%0d exp=5", bus.sample_cnt); end
    bus.start = 1'b1; bus.ecg_valid = 1'b1; bus.ecg_input = 8'd255;
    step();
    bus.start = 1'b0; bus.ecg_valid = 1'b0;
    total++; if (bus.sample_cnt !== 4'd0) begin bad++; $display("FAIL rs_cnt0 got=%0d exp=0", bus.sample_cnt); end
    total++; if (bus.class_valid !== 1'b0) begin bad++; $display("FAIL rs_cv got=%b exp=0", bus.class_valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rs_busy got=%b exp=1", bus.busy); end
    for (int i = 0; i < 15; i++) feed(8'd7);
    step();
    total++; if (bus.classifier !== 4'b0001) begin bad++; $display("FAIL rs_class got=%b exp=0001", bus.classifier); end
    step();
  endtask

  task automatic test_mid_reset();
    start_frame();
    for (int i = 0; i < 7; i++) feed((i % 2 == 0) ? 8'd0 : 8'd255);
    rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b exp=0", bus.busy); end
    total++; if (bus.sample_cnt !== 4'd0) begin bad++; $display("FAIL mr_cnt got=%0d exp=0", bus.sample_cnt); end
    total++; if (bus.classifier !== 4'b0000) begin bad++; $display("FAIL mr_class got=%b exp=0000", bus.classifier); end
    total++; if (bus.class_valid !== 1'b0) begin bad++; $display("FAIL mr_cv got=%b exp=0", bus.class_valid); end
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 18; i++) begin
      if (i < 15) feed((i % 2 == 0) ? 8'd0 : 8'd255);
      else step();
      total++;
      if (bus.class_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL mr_idle[%0d] got cv=%b busy=%b exp cv=0 busy=0", i, bus.class_valid, bus.busy);
      end
    end
    start_frame();
    feed(8'd10); feed(8'd18);
    for (int i = 0; i < 13; i++) feed(8'd12);
    step();
    total++; if (bus.classifier !== 4'b0010) begin bad++; $display("FAIL mr_class2 got=%b exp=0010", bus.classifier); end
    step();
  endtask

  task automatic test_back_to_back();
    start_frame();
    feed(8'd5); feed(8'd12);
    for (int i = 0; i < 13; i++) feed(8'd9);
    step();
    total++; if (bus.classifier !== 4'b0001) begin bad++; $display("FAIL b2b_class1 got=%b exp=0001", bus.classifier); end
    total++; if (bus.class_valid !== 1'b1) begin bad++; $display("FAIL b2b_cv1 got=%b exp=1", bus.class_valid); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
    total++; if (bus.sample_cnt !== 4'd0) begin bad++; $display("FAIL b2b_cnt got=%0d exp=0", bus.sample_cnt); end
    for (int i = 0; i < 15; i++) feed(f1[i]);
    step();
    total++; if (bus.class_valid !== 1'b1) begin bad++; $display("FAIL b2b_cv2 got=%b exp=1", bus.class_valid); end
    total++; if (bus.classifier !== 4'b0100) begin bad++; $display("FAIL b2b_class2 got=%b exp=0100", bus.classifier); end
`ifdef ECG_FEAT_OUT_EN
    total++; if (feat_max !== 8'd16) begin bad++; $display("FAIL feat_max got=%0d exp=16", feat_max); end
    total++; if (feat_min !== 8'd0) begin bad++; $display("FAIL feat_min got=%0d exp=0", feat_min); end
    total++; if (feat_sum !== 12'd103) begin bad++; $display("FAIL feat_sum got=%0d exp=103", feat_sum); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_frame1();
    test_flat();
    test_extremes();
    test_valid_gaps();
    test_restart();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecg_frame_classifier.md
# ecg_frame_classifier

Parametrised successor to the fixed 8-bit ECG classifier top. It collects a frame of `FRAME_LEN` ECG samples under a valid qualifier and tracks running peak, trough and sum. It then classifies the frame by peak-to-peak range into `NUM_CLASS` one-hot classes. It sits between the ECG sample source and downstream class-consumer logic, and adds sample gating, restart and a result-valid handshake.

## Interface
- `DATA_W`, default 8: unsigned sample width.
- `FRAME_LEN`, default 15: samples per frame; must be ≥ 2.
- `NUM_CLASS`, default 4: number of classes, which is also the `classifier` width; must be ≥ 2.
- `BIN_SHIFT`, default 3: range bin size is 2^`BIN_SHIFT` codes.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `start`  in  1  begin or restart frame acquisition.
- `ecg_valid`  in  1  `ecg_input` carries a sample this cycle.
- `ecg_input`  in  `DATA_W`  unsigned ECG sample.
- `busy`  out  1  high in ACQ and CLASSIFY.
- `sample_cnt`  out  `$clog2(FRAME_LEN+1)`  samples accepted in the current frame.
- `classifier`  out  `NUM_CLASS`  one-hot class of the last completed frame.
- `class_valid`  out  1  one-cycle pulse when `classifier` updates.

## Operation
- FSM states are IDLE, ACQ, CLASSIFY and DONE. The reset state is IDLE.
- IDLE: `start`=1 moves to ACQ. Entry to ACQ clears the feature registers: max←0, min←all-ones, sum←0, `sample_cnt`←0.
- ACQ: each cycle with `ecg_valid`=1 accepts the sample:
  - max←max(max, x); min←min(min, x); sum←sum+x; `sample_cnt`++.
  - The accept that brings `sample_cnt` to `FRAME_LEN` moves the FSM to CLASSIFY.
  - Cycles with `ecg_valid`=0 change nothing.
- `start`=1 in ACQ restarts the frame: features and count are cleared and the state stays ACQ. A sample presented in the same cycle is discarded.
- CLASSIFY:
  - range = max − min, unsigned, `DATA_W` bits, never negative.
  - k = range >> `BIN_SHIFT`, saturated to `NUM_CLASS`−1.
  - `classifier`←(1<<k), `class_valid`←1, next state DONE.
- DONE: lasts one cycle, then the FSM goes to IDLE. If `start`=1 in DONE, it goes directly to ACQ instead. `start` is ignored in CLASSIFY.
- `classifier` holds its value until the next CLASSIFY. It is never all-zero after the first frame.
- `sum` width is `DATA_W`+`$clog2(FRAME_LEN)`. It is sized so it cannot overflow, so no wrap is possible.
- Reset values of all outputs: `busy`=0, `sample_cnt`=0, `classifier`=0, `class_valid`=0. Reset asserted mid-frame aborts the frame immediately; no partial result is produced.

## Timing
- From `start` sampled in IDLE, ACQ is active on the next cycle; the first sample can be accepted on that cycle's edge.
- The last sample is accepted at edge E. CLASSIFY is the cycle after E. `classifier` and `class_valid`=1 appear after edge E+1 (in DONE). `class_valid` returns to 0 after E+2.
- Latency from the final accepted sample to the result is 2 edges, independent of gaps in `ecg_valid`.
- `busy` is 1 from the edge that enters ACQ until the edge that enters DONE.
- Back-to-back frames: with `start` held in DONE, the next frame's first sample can be accepted on the cycle after DONE.

## Configuration
- `ECG_FEAT_OUT_EN` defined:
  - Adds output ports `feat_max` (`DATA_W`), `feat_min` (`DATA_W`) and `feat_sum` (`DATA_W`+`$clog2(FRAME_LEN)`).
  - These ports are registered in CLASSIFY alongside `classifier`, reset to 0, and are held until the next classification.
- Undefined: the ports do not exist, the feature registers are internal only, and classification behaviour is identical.

## Test plan
- Default params, continuous `ecg_valid`, samples 16,15,7,3,0,3,5,6,6,7,7,7,7,7,7 -> range 16, k=2, `classifier`=4'b0100; `class_valid` is high for exactly one cycle, 2 edges after the 15th sample.
- Flat frame, 15 samples of 7 -> range 0, `classifier`=4'b0001.
- Frame containing 0 and 255 -> range 255, k clamps to 3, `classifier`=4'b1000.
- Frame 1 with `ecg_valid` toggling 1/0 -> same result as frame 1 with continuous valid; invalid cycles do not change `sample_cnt`.
- `start` pulsed after 5 samples, then 15 more samples of 7 -> `sample_cnt` returns to 0, `classifier`=4'b0001, no pulse after the 5th sample.
- `rst`=0 mid-ACQ -> all outputs 0 and state IDLE; no `class_valid` until a fresh `start` plus 15 samples.
- With `ECG_FEAT_OUT_EN` and the frame 1 stimulus -> `feat_max`=16, `feat_min`=0, `feat_sum`=103.
